// File: rtl/main_memory_pkg.sv
// Shared types and constants for the main memory controller.
// Contents: FSM state enum, operation enum, data width and latency counter width.
package main_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int MAIN_MEMORY_READ_SIZE = 32;
    localparam int CNT_WIDTH             = 4;

endpackage

// File: rtl/main_memory_array.sv
// Single-port synchronous RAM with registered read and per-byte write enables.
// Kept separate so it can be replaced by a vendor macro.
// Ports:
//   clk, rst - clock and asynchronous active-high reset (read register only)
//   en       - access enable for this cycle
//   we       - 1 = write, 0 = read
//   be       - byte-lane write enables
//   addr     - word index
//   wdata    - write data
//   rdata    - registered read data, holds until the next read
module main_memory_array
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = MAIN_MEMORY_READ_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Word-addressed main memory with a configurable access-latency FSM.
// A request sampled in IDLE completes LATENCY edges later with a one-cycle
// mem_ready pulse; one request is outstanding at a time.
// Optional feature macro: MAIN_MEMORY_BYTE_WRITE_EN (adds wr_strb byte lanes).
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   mem_addr  - byte address; word index is mem_addr[ADDR_WIDTH+1:2]
//   en_mem_re - read request level
//   en_mem_wr - write request level (wins over read when both are high)
//   wr_data   - write data
//   wr_strb   - byte-lane enables (only with MAIN_MEMORY_BYTE_WRITE_EN)
//   data_out  - registered read data, holds the last read value
//   mem_ready - one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for a request; inputs are sampled only here
// ACCESS | counting down the latency; op performed when counter reaches 0
// RESP   | mem_ready high for this single cycle, then back to IDLE
module main_memory_ctrl
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3,
    parameter int READ_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_addr,
    input  logic                 en_mem_re,
    input  logic                 en_mem_wr,
    input  logic [31:0]          wr_data,
`ifdef MAIN_MEMORY_BYTE_WRITE_EN
    input  logic [3:0]           wr_strb,
`endif
    output logic [READ_SIZE-1:0] data_out,
    output logic                 mem_ready
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("main_memory_ctrl: LATENCY must be in 1..15");
        end
        if (READ_SIZE != MAIN_MEMORY_READ_SIZE) begin : g_bad_read_size
            $error("main_memory_ctrl: READ_SIZE must equal MAIN_MEMORY_READ_SIZE");
        end
    endgenerate

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    state_t                state_d, state_q;
    op_t                   op_d, op_q;
    logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [31:0]           wdata_d, wdata_q;
    logic [3:0]            strb_d, strb_q;
    logic                  mem_ready_d, mem_ready_q;
    logic                  ram_en;

    logic [3:0] req_strb;
`ifdef MAIN_MEMORY_BYTE_WRITE_EN
    assign req_strb = wr_strb;
`else
    assign req_strb = 4'hF;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        mem_ready_d = 1'b0;
        ram_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en_mem_re || en_mem_wr) begin
                    addr_d  = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d = wr_data;
                    strb_d  = req_strb;
                    op_d    = en_mem_wr ? OP_WRITE : OP_READ;
                    cnt_d   = CNT_WIDTH'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // The array op lands on the same edge that raises mem_ready,
                    // so read data is valid for the whole ready cycle.
                    ram_en      = 1'b1;
                    mem_ready_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    main_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (READ_SIZE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (op_q == OP_WRITE),
        .be    (strb_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (data_out)
    );

    assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
module tb_main_memory_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        en_mem_re = 1'b0;
    logic        en_mem_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  strb_drv = 4'hF;
    logic [31:0] data_out;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] last_read = '0;

    logic [31:0] exp_data_q [$];
    int          exp_cyc_q  [$];
    logic        prev_ready = 1'b0;

    main_memory_ctrl #(
        .ADDR_WIDTH (10),
        .LATENCY    (LAT),
        .READ_SIZE  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .en_mem_re (en_mem_re),
        .en_mem_wr (en_mem_wr),
        .wr_data   (wr_data),
`ifdef MAIN_MEMORY_BYTE_WRITE_EN
        .wr_strb   (strb_drv),
`endif
        .data_out  (data_out),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: compares whenever the DUT presents mem_ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_ready) begin
                checks++;
                if (prev_ready) begin
                    errors++;
                    $display("FAIL ready_consecutive: mem_ready high two cycles in a row at cycle %0d", cyc);
                end
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: mem_ready with no pending request at cycle %0d", cyc);
                end else begin
                    logic [31:0] ed;
                    int          ec;
                    ed = exp_data_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    checks++;
                    if (data_out !== ed) begin
                        errors++;
                        $display("FAIL data_out: got %h expected %h at cycle %0d", data_out, ed, cyc);
                    end
                    checks++;
                    if (cyc != ec + LAT) begin
                        errors++;
                        $display("FAIL ready_latency: ready at cycle %0d expected %0d", cyc, ec + LAT);
                    end
                end
            end
            prev_ready <= mem_ready;
        end else begin
            prev_ready <= 1'b0;
        end
    end

    task automatic wait_ready();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no mem_ready within 40 cycles at cycle %0d", cyc);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns likewise.
    task automatic do_req(input logic [31:0] addr, input logic re, input logic wr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [31:0] exp);
        mem_addr  = addr;
        en_mem_re = re;
        en_mem_wr = wr;
        wr_data   = data;
        strb_drv  = strb;
        @(posedge clk);
        #1;
        exp_data_q.push_back(exp);
        exp_cyc_q.push_back(cyc);
        // Scramble inputs to show they are latched.
        en_mem_re = 1'b0;
        en_mem_wr = 1'b0;
        mem_addr  = 32'hFFFF_FFFF;
        wr_data   = ~data;
        strb_drv  = ~strb;
        wait_ready();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        do_req(addr, 1'b0, 1'b1, data, strb, last_read);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        do_req(addr, 1'b1, 1'b0, 32'h0, 4'hF, exp);
        last_read = exp;
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data_out: got %h expected 00000000", data_out);
        end
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_ready: got %b expected 0", mem_ready);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        rd(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0013, 32'hDEAD_BEEF);

        // Held read: 20 cycles, pulses every LAT+2 cycles, 4 total
        mem_addr  = 32'h0000_0010;
        en_mem_re = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_data_q.push_back(32'hDEAD_BEEF);
            exp_cyc_q.push_back(s + k * (LAT + 2));
        end
        repeat (19) @(posedge clk);
        @(negedge clk);
        en_mem_re = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL held_read_pulses: %0d pulses missing, expected 0 missing", exp_data_q.size());
        end
        exp_data_q.delete();
        exp_cyc_q.delete();

        // Simultaneous enables: write wins, data_out unchanged
        do_req(32'h0000_0020, 1'b1, 1'b1, 32'h1234_5678, 4'hF, last_read);
        rd(32'h0000_0020, 32'h1234_5678);

        // Reset mid-operation
        wr(32'h0000_0030, 32'h0BAD_F00D, 4'hF);
        mem_addr  = 32'h0000_0030;
        en_mem_wr = 1'b1;
        wr_data   = 32'h1111_2222;
        @(posedge clk);
        #1;
        en_mem_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_data_out: got %h expected 00000000", data_out);
        end
        last_read = 32'h0;
        rd(32'h0000_0030, 32'h0BAD_F00D);

        // Address wrap
        wr(32'h0000_1004, 32'hA5A5_A5A5, 4'hF);
        rd(32'h0000_0004, 32'hA5A5_A5A5);

`ifdef MAIN_MEMORY_BYTE_WRITE_EN
        wr(32'h0000_0040, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0000_0040, 32'h00AB_0000, 4'b0100);
        rd(32'h0000_0040, 32'hFFAB_FFFF);
        wr(32'h0000_0040, 32'h0000_0000, 4'b0000);
        rd(32'h0000_0040, 32'hFFAB_FFFF);
`else
        wr(32'h0000_0040, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0000_0040, 32'h00AB_0000, 4'b0100);
        rd(32'h0000_0040, 32'h00AB_0000);
`endif

        repeat (4) @(negedge clk);
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_data_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
